// File: rtl/sync_fifo_cntrl.sv
// Single-clock FIFO: storage array, pointer control, occupancy count and status flags.
// Read port is registered; flags are registered from the next-cycle occupancy.
module sync_fifo_cntrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_inc,
    input  logic [DATA_WIDTH-1:0] W_data,
    input  logic                  R_inc,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] R_data,
    output logic                  R_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] wptr_nxt;
    logic [ADDR_WIDTH-1:0] rptr_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  rd_en;
    logic                  wr_en;
    logic                  ovf_set;
    logic                  unf_set;

    always_comb begin
        rd_en     = R_inc & ~empty;
        // A write into a full FIFO is only legal when a read frees a slot on the same edge.
        wr_en     = W_inc & (~full | rd_en);
        ovf_set   = W_inc & ~wr_en;
        unf_set   = R_inc & empty;

        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = count;

        if (wr_en) begin
            wptr_nxt = (wptr == PTR_MAX) ? '0 : wptr + PTR_ONE;
        end
        if (rd_en) begin
            rptr_nxt = (rptr == PTR_MAX) ? '0 : rptr + PTR_ONE;
        end

        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately left out of reset; R_data can only expose written words.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wptr] <= W_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
            count <= count_nxt;
        end
    end

    // Read-while-full picks up the pre-edge word, since the write into the same slot is non-blocking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            R_data  <= '0;
            R_valid <= 1'b0;
        end else begin
            R_valid <= rd_en;
            if (rd_en) begin
                R_data <= mem[rptr];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
        end
    end

    // Set has priority over clear so a rejection in the clearing cycle is never lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_cntrl.sv
// Directed bench for sync_fifo_cntrl (DEPTH=8, DATA_WIDTH=8, thresholds 6/2).
// Expected values are hand-derived from the FIFO behaviour, one task per scenario.
module tb_sync_fifo_cntrl;

    logic       CLK;
    logic       RST;
    logic       W_inc;
    logic [7:0] W_data;
    logic       R_inc;
    logic       clr_err;
    logic [7:0] R_data;
    logic       R_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sync_fifo_cntrl #(
        .DATA_WIDTH   (8),
        .DEPTH        (8),
        .AFULL_THRESH (6),
        .AEMPTY_THRESH(2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .W_inc       (W_inc),
        .W_data      (W_data),
        .R_inc       (R_inc),
        .clr_err     (clr_err),
        .R_data      (R_data),
        .R_valid     (R_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {full, empty, almost_full, almost_empty, overflow, underflow, R_valid}
    function automatic logic [6:0] status();
        return {full, empty, almost_full, almost_empty, overflow, underflow, R_valid};
    endfunction

    // One clock of stimulus; outputs are then sampled 1 ns after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        W_inc   = w;
        W_data  = d;
        R_inc   = r;
        clr_err = c;
        @(posedge CLK);
        #1;
        W_inc   = 1'b0;
        R_inc   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (status() !== 7'b0101000) $display("FAIL reset_flags got %b exp %b", status(), 7'b0101000);
        else pass_cnt++;
        total_cnt++;
        if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count);
        else pass_cnt++;
        total_cnt++;
        if (R_data !== 8'h00) $display("FAIL reset_rdata got %h exp 00", R_data);
        else pass_cnt++;
    endtask

    task automatic test_fill_overflow();
        logic [6:0] exp;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'(i * 17), 1'b0, 1'b0);
            exp = {i == 8, 1'b0, i >= 6, i <= 2, 3'b000};
            total_cnt++;
            if (count !== 4'(i)) $display("FAIL fill_count i=%0d got %0d exp %0d", i, count, i);
            else pass_cnt++;
            total_cnt++;
            if (status() !== exp) $display("FAIL fill_flags i=%0d got %b exp %b", i, status(), exp);
            else pass_cnt++;
        end
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        total_cnt++;
        if (count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", count);
        else pass_cnt++;
        total_cnt++;
        if (status() !== 7'b1010100) $display("FAIL ovf_flags got %b exp %b", status(), 7'b1010100);
        else pass_cnt++;
    endtask

    task automatic test_drain_underflow();
        logic [6:0] exp;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            exp = {1'b0, i == 8, (8 - i) >= 6, (8 - i) <= 2, 1'b1, 1'b0, 1'b1};
            total_cnt++;
            if (R_data !== 8'(i * 17)) $display("FAIL drain_data i=%0d got %h exp %h", i, R_data, 8'(i * 17));
            else pass_cnt++;
            total_cnt++;
            if (count !== 4'(8 - i)) $display("FAIL drain_count i=%0d got %0d exp %0d", i, count, 8 - i);
            else pass_cnt++;
            total_cnt++;
            if (status() !== exp) $display("FAIL drain_flags i=%0d got %b exp %b", i, status(), exp);
            else pass_cnt++;
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        total_cnt++;
        if (status() !== 7'b0101110) $display("FAIL unf_flags got %b exp %b", status(), 7'b0101110);
        else pass_cnt++;
        total_cnt++;
        if (count !== 4'd0 || R_data !== 8'h88)
            $display("FAIL unf_hold got count=%0d data=%h exp count=0 data=88", count, R_data);
        else pass_cnt++;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        total_cnt++;
        if ({overflow, underflow} !== 2'b00) $display("FAIL clr_both got %b exp 00", {overflow, underflow});
        else pass_cnt++;
    endtask

    task automatic test_full_rw();
        logic [7:0] exp;
        for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i * 17), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'hAA, 1'b1, 1'b0);
            total_cnt++;
            if (R_data !== 8'((k + 1) * 17)) $display("FAIL frw_data k=%0d got %h exp %h", k, R_data, 8'((k + 1) * 17));
            else pass_cnt++;
            total_cnt++;
            if (count !== 4'd8 || status() !== 7'b1010001)
                $display("FAIL frw_state k=%0d got count=%0d flags=%b exp count=8 flags=1010001", k, count, status());
            else pass_cnt++;
        end
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            exp = (k < 5) ? 8'((k + 4) * 17) : 8'hAA;
            total_cnt++;
            if (R_data !== exp || R_valid !== 1'b1)
                $display("FAIL frw_drain k=%0d got %h/%b exp %h/1", k, R_data, R_valid, exp);
            else pass_cnt++;
            total_cnt++;
            if (count !== 4'(7 - k)) $display("FAIL frw_count k=%0d got %0d exp %0d", k, count, 7 - k);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        for (int v = 0; v < 20; v++) begin
            cyc(1'b1, 8'(v), 1'b0, 1'b0);
            total_cnt++;
            if (count !== 4'd1 || R_valid !== 1'b0)
                $display("FAIL wrap_wr v=%0d got count=%0d rv=%b exp 1/0", v, count, R_valid);
            else pass_cnt++;
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            total_cnt++;
            if (R_data !== 8'(v) || R_valid !== 1'b1 || count !== 4'd0)
                $display("FAIL wrap_rd v=%0d got data=%h rv=%b count=%0d exp %h/1/0", v, R_data, R_valid, count, 8'(v));
            else pass_cnt++;
        end
    endtask

    task automatic test_err_and_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i * 17), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL err_set got %b exp 1", overflow);
        else pass_cnt++;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL err_clr got %b exp 0", overflow);
        else pass_cnt++;
        cyc(1'b1, 8'h66, 1'b0, 1'b1);
        total_cnt++;
        if (overflow !== 1'b1 || count !== 4'd8)
            $display("FAIL err_setwins got ovf=%b count=%0d exp 1/8", overflow, count);
        else pass_cnt++;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        total_cnt++;
        if (R_valid !== 1'b1 || R_data !== 8'h11)
            $display("FAIL pre_rst_read got %b/%h exp 1/11", R_valid, R_data);
        else pass_cnt++;
        #1 RST = 1'b1;
        #1;
        total_cnt++;
        if (status() !== 7'b0101000 || count !== 4'd0 || R_data !== 8'h00)
            $display("FAIL async_rst got flags=%b count=%0d data=%h exp 0101000/0/00", status(), count, R_data);
        else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        total_cnt++;
        if (R_data !== 8'h5A || R_valid !== 1'b1 || count !== 4'd0)
            $display("FAIL post_rst got data=%h rv=%b count=%0d exp 5A/1/0", R_data, R_valid, count);
        else pass_cnt++;
    endtask

    initial begin
        RST     = 1'b1;
        W_inc   = 1'b0;
        W_data  = 8'h00;
        R_inc   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        @(negedge CLK);
        RST = 1'b0;
        test_fill_overflow();
        test_drain_underflow();
        test_full_rw();
        test_wrap();
        test_err_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sync_fifo_cntrl.md
Name: sync_fifo_cntrl

Overview:
Single-clock, parametrised FIFO: storage array, pointer control and status flags in one block. Successor to the dual-clock memory controller. Used wherever producer and consumer share a clock (e.g. UART/ALU result buffering inside the system domain). Adds the following over the previous generation:
- registered read port
- occupancy count
- programmable almost-full/almost-empty thresholds
- read-while-full pass-through
- sticky overflow/underflow error flags

Parameters:
DATA_WIDTH, 8, width of each data word.
DEPTH, 8, number of entries; power of two, >= 2.
AFULL_THRESH, 6, almost_full asserts when count >= this value; range 1..DEPTH.
AEMPTY_THRESH, 2, almost_empty asserts when count <= this value; range 0..DEPTH-1.
ADDR_WIDTH (localparam), $clog2(DEPTH), pointer/index width. Derived from DEPTH, never from DATA_WIDTH.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST  input  1  asynchronous, active-high reset.
W_inc  input  1  write request.
W_data  input  DATA_WIDTH  write data, sampled with W_inc.
R_inc  input  1  read request.
clr_err  input  1  synchronous clear of overflow/underflow.
R_data  output  DATA_WIDTH  registered read data.
R_valid  output  1  one-cycle pulse; R_data holds a newly popped word.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AFULL_THRESH.
almost_empty  output  1  count <= AEMPTY_THRESH.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (RST=1, asynchronous, dominates all else):
  - wptr=0, rptr=0, count=0.
  - R_data=0, R_valid=0, overflow=0, underflow=0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (flags follow count).
  - Memory array is NOT reset. Contents are undefined until written; never observable on R_data before a write.
- Accept rules, evaluated on registered state:
  - rd_en = R_inc & ~empty.
  - wr_en = W_inc & (~full | rd_en). Write while full is accepted only if a read is accepted in the same cycle.
- On wr_en: mem[wptr] <= W_data; wptr <= wptr+1, wrapping DEPTH-1 -> 0.
- On rd_en: R_data <= mem[rptr]; rptr <= rptr+1 with wrap; R_valid <= 1.
  - Otherwise R_valid <= 0 and R_data holds its value.
- Read latency: word presented on R_data and R_valid one edge after the accepting edge.
- Simultaneous read and write when empty:
  - Read rejected (underflow set), write accepted.
  - No bypass: the word is readable from the next cycle.
- Simultaneous read and write with 0 < count < DEPTH: both accepted, count unchanged.
- Simultaneous read and write when full: both accepted, count stays DEPTH, full stays 1.
  - Read returns the oldest entry; the write lands in the freed slot (wptr == rptr before the edge; read uses the pre-edge contents).
- count update: count <= count + wr_en - rd_en. Never exceeds DEPTH, never below 0.
- Flags:
  - full, empty, almost_full, almost_empty are registered, computed from next-count.
  - They change on the same edge as count; no combinational path from W_inc/R_inc to any output.
- Error flags:
  - overflow <= 1 when W_inc & ~wr_en.
  - underflow <= 1 when R_inc & empty.
  - clr_err clears both flags the next edge.
  - Set wins over clear in the same cycle.
  - Rejected requests modify no pointer, count or memory location.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight R_valid is dropped.

Test Plan:
1. Reset with DEPTH=8, DATA_WIDTH=8 -> empty=1, almost_empty=1, count=0, R_data=0x00, R_valid=0, overflow=0, underflow=0.
2. Write 0x11..0x88 (8 words), then one more W_inc with 0x99 -> full=1 after 8th write, almost_full=1 from count=6, count=8, overflow=1, 0x99 not stored.
3. Read 8 times -> R_data = 0x11..0x88 in order, each one cycle after its R_inc, R_valid pulses 8 times; ninth R_inc -> underflow=1, count=0, R_valid=0.
4. Fill to full, then W_inc=R_inc=1 with 0xAA for 3 cycles -> reads return 0x11, 0x22, 0x33; count stays 8; overflow stays 0; later reads end with 0xAA x3.
5. Pointer wrap: 20 cycles of alternating single write/read (values 0..19) -> every value read back correctly with count ≤1, exercising wrap at 7->0 twice.
6. Set overflow, assert clr_err alone -> overflow=0 next cycle; assert clr_err together with a rejected write -> overflow stays 1. Then assert RST mid-burst -> all outputs at reset values asynchronously.
